// File: rtl/arinc429_pkg.sv
// Shared constants, FSM state type and half-bit period helper for the ARINC 429 transmitter.
package arinc429_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned HALF_W = 16;

   localparam logic [1:0] SPEED_OFF  = 2'b00;
   localparam logic [1:0] SPEED_12K5 = 2'b01;
   localparam logic [1:0] SPEED_50K  = 2'b10;
   localparam logic [1:0] SPEED_100K = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BIT_HI,
      ST_BIT_LO,
      ST_GAP
   } state_e;

   // Clocks per half bit; zero for the OFF setting, which never starts a word.
   function automatic logic [HALF_W-1:0] half_period(input logic [1:0] speed,
                                                     input int unsigned clk_hz);
      int unsigned rate;
      case (speed)
         SPEED_12K5: rate = 32'd12500;
         SPEED_50K:  rate = 32'd50000;
         SPEED_100K: rate = 32'd100000;
         default:    rate = 32'd0;
      endcase
      if (rate == 32'd0) return '0;
      return HALF_W'(clk_hz / (32'd2 * rate));
   endfunction

endpackage

// File: rtl/arinc429_tx_if.sv
// Avalon-ST sink bundle feeding the ARINC 429 transmitter.
interface arinc429_tx_if;

   logic                              i_snk_tx_valid;
   logic [arinc429_pkg::WORD_W-1:0]   i_snk_tx_data;
   logic                              o_snk_tx_ready;

   modport master (
      output i_snk_tx_valid,
      output i_snk_tx_data,
      input  o_snk_tx_ready
   );

   modport slave (
      input  i_snk_tx_valid,
      input  i_snk_tx_data,
      output o_snk_tx_ready
   );

endinterface

// File: rtl/arinc429_bit_timer.sv
// Half-bit tick generator: HALF is captured on load, the counter runs only while enabled.
module arinc429_bit_timer
   import arinc429_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [HALF_W-1:0] i_half,
   output logic              o_tick,
   output logic              o_pre_tick
);

   logic [HALF_W-1:0] cnt_q, cnt_d;
   logic [HALF_W-1:0] half_q, half_d;

   assign o_tick     = i_en && (cnt_q == half_q - HALF_W'(1));
   // One cycle ahead of o_tick, used where an output must be registered in time.
   assign o_pre_tick = i_en && (cnt_q == half_q - HALF_W'(2));

   always_comb begin
      half_d = i_load ? i_half : half_q;
      cnt_d  = cnt_q;
      if (i_load || !i_en) begin
         cnt_d = '0;
      end else if (o_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + HALF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         half_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

endmodule

// File: rtl/arinc429_tx.sv
// ARINC 429 transmitter: Avalon-ST words serialised onto the bipolar RZ A/B line pair.
// Optional ARINC429_TX_PARITY_GEN_EN replaces bit 31 with odd parity over bits 30:0.
module arinc429_tx
   import arinc429_pkg::*;
#(
   parameter int unsigned IN_AVS_CLK = 32'd50000000,
   parameter int unsigned GAP_BITS   = 4
) (
   input  logic           i_avs_clk,
   input  logic           i_avs_rst,
   arinc429_tx_if.slave   snk,
   input  logic [1:0]     i_arinc429_speed,
   output logic           o_arinc429_tx_A,
   output logic           o_arinc429_tx_B,
   output logic           o_arinc429_tx_busy,
   output logic           o_arinc429_tx_done
);

   localparam int unsigned GAP_TICKS = 2 * GAP_BITS;
   localparam int unsigned GAP_W     = $clog2(GAP_TICKS);
   localparam int unsigned BIT_W     = $clog2(WORD_W);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic                a_q, a_d, b_q, b_d;
   logic                busy_q, busy_d, ready_q, ready_d, done_q, done_d;
   logic                accept, tick, pre_tick;
   logic [WORD_W-1:0]   word_in;
   logic [HALF_W-1:0]   half_sel;

   assign accept   = (state_q == ST_IDLE) && ready_q && snk.i_snk_tx_valid
                     && (i_arinc429_speed != SPEED_OFF);
   assign half_sel = half_period(i_arinc429_speed, IN_AVS_CLK);

`ifdef ARINC429_TX_PARITY_GEN_EN
   assign word_in = {~^snk.i_snk_tx_data[WORD_W-2:0], snk.i_snk_tx_data[WORD_W-2:0]};
`else
   assign word_in = snk.i_snk_tx_data;
`endif

   arinc429_bit_timer u_bit_timer (
      .clk        (i_avs_clk),
      .rst        (i_avs_rst),
      .i_load     (accept),
      .i_en       (state_q != ST_IDLE),
      .i_half     (half_sel),
      .o_tick     (tick),
      .o_pre_tick (pre_tick)
   );

   always_ff @(posedge i_avs_clk or posedge i_avs_rst) begin
      if (i_avs_rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   // The gap ends one clock before its last tick so the registered ready is up on the
   // first IDLE cycle and the word period stays exactly (32 + GAP_BITS) bit times.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shreg_d   = word_in;
               bit_cnt_d = '0;
               state_d   = ST_BIT_HI;
            end
         end
         ST_BIT_HI: begin
            if (tick) state_d = ST_BIT_LO;
         end
         ST_BIT_LO: begin
            if (tick) begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == '1) begin
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  state_d = ST_BIT_HI;
               end
            end
         end
         ST_GAP: begin
            if (tick) gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (pre_tick && (gap_cnt_q == GAP_W'(GAP_TICKS - 1))) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_d     = (state_d == ST_BIT_HI) && shreg_d[0];
      b_d     = (state_d == ST_BIT_HI) && !shreg_d[0];
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE) && (i_arinc429_speed != SPEED_OFF);
      done_d  = (state_q == ST_BIT_LO) && (bit_cnt_q == '1) && pre_tick;
   end

   assign o_arinc429_tx_A    = a_q;
   assign o_arinc429_tx_B    = b_q;
   assign o_arinc429_tx_busy = busy_q;
   assign o_arinc429_tx_done = done_q;
   assign snk.o_snk_tx_ready = ready_q;

endmodule

// File: tb/tb_arinc429_tx.sv
// Directed bench for arinc429_tx at a 1 MHz model clock (HALF = 40/10/5 clocks).
module tb_arinc429_tx;
   import arinc429_pkg::*;

   localparam int unsigned CLK_HZ   = 1000000;
   localparam int unsigned GAP_BITS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic       a, b, busy, done;

   arinc429_tx_if bus ();

   arinc429_tx #(.IN_AVS_CLK(CLK_HZ), .GAP_BITS(GAP_BITS)) dut (
      .i_avs_clk          (clk),
      .i_avs_rst          (rst),
      .snk                (bus),
      .i_arinc429_speed   (speed),
      .o_arinc429_tx_A    (a),
      .o_arinc429_tx_B    (b),
      .o_arinc429_tx_busy (busy),
      .o_arinc429_tx_done (done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int overlap  = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (a && b) overlap++;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] tx_image(input logic [31:0] d);
      logic [31:0] r;
      r = d;
`ifdef ARINC429_TX_PARITY_GEN_EN
      r[31] = (($countones(d[30:0]) % 2) == 0);
`endif
      return r;
   endfunction

   typedef struct {
      logic [1:0]  spd;
      logic [31:0] data;
      int          half;
      int          chg_bit;
      logic [1:0]  chg_spd;
      logic        exp_ready;
   } vec_t;

   // Sends one word (caller is at a negedge) and decodes/times the line until busy drops.
   task automatic run_word(input string tag, input logic [1:0] spd, input logic [31:0] data,
                           input int half, input int chg_bit, input logic [1:0] chg_spd,
                           input logic exp_ready);
      int to, hl, ll, bad, dn, t_done, quiet;
      logic [31:0] w;
      speed = spd;
      bus.i_snk_tx_data  = data;
      bus.i_snk_tx_valid = 1'b1;
      to = 0;
      while (!bus.o_snk_tx_ready && to < 1000) begin
         @(negedge clk);
         to++;
      end
      check({tag, "_accept_timeout"}, longint'(to < 1000), 1);
      @(posedge clk);
      #1 bus.i_snk_tx_valid = 1'b0;
      @(negedge clk);
      check({tag, "_latency"}, longint'(a | b), 1);
      bad = 0; dn = 0; quiet = 0; w = '0;
      for (int i = 0; i < 32; i++) begin
         if (i == chg_bit) speed = chg_spd;
         w[i] = a;
         hl = 0;
         while ((a | b) && hl < 4 * half + 8) begin
            if (done) dn++;
            hl++;
            @(negedge clk);
         end
         if (hl != half) bad++;
         if (i < 31) begin
            ll = 0;
            while (!(a | b) && ll < 4 * half + 8) begin
               if (done) dn++;
               ll++;
               @(negedge clk);
            end
            if (ll != half) bad++;
         end
      end
      ll = 0; t_done = -1;
      while (busy && ll < 20 * half + 20) begin
         if (done) begin
            dn++;
            if (t_done < 0) t_done = ll;
         end
         if (a | b) quiet++;
         ll++;
         @(negedge clk);
      end
      check({tag, "_word"}, w, tx_image(data));
      check({tag, "_halfbit_errors"}, bad, 0);
      check({tag, "_done_pulses"}, dn, 1);
      check({tag, "_done_at_last_half_end"}, t_done, half - 1);
      check({tag, "_gap_len"}, ll - t_done, 2 * GAP_BITS * half);
      check({tag, "_gap_null"}, quiet, 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_ready_end"}, bus.o_snk_tx_ready, exp_ready);
   endtask

   initial begin
      vec_t vecs [6];
      int   to, seen, t1, t2;

      vecs[0] = '{spd: 2'b11, data: 32'h0000_0001, half: 5,  chg_bit: -1, chg_spd: 2'b00, exp_ready: 1'b1};
      vecs[1] = '{spd: 2'b10, data: 32'hA5A5_5A5A, half: 10, chg_bit: -1, chg_spd: 2'b00, exp_ready: 1'b1};
      vecs[2] = '{spd: 2'b11, data: 32'h8000_0001, half: 5,  chg_bit: 10, chg_spd: 2'b01, exp_ready: 1'b1};
      vecs[3] = '{spd: 2'b01, data: 32'h0000_0003, half: 40, chg_bit: -1, chg_spd: 2'b00, exp_ready: 1'b1};
      vecs[4] = '{spd: 2'b10, data: 32'hFFFF_FFFF, half: 10, chg_bit: 5,  chg_spd: 2'b00, exp_ready: 1'b0};
      vecs[5] = '{spd: 2'b11, data: 32'h7FFF_FFFE, half: 5,  chg_bit: -1, chg_spd: 2'b00, exp_ready: 1'b1};

      rst = 1'b1;
      speed = 2'b11;
      bus.i_snk_tx_valid = 1'b0;
      bus.i_snk_tx_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.o_snk_tx_ready, 0);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", bus.o_snk_tx_ready, 1);
      check("idle_busy", busy, 0);

      for (int v = 0; v < 6; v++) begin
         run_word($sformatf("vec%0d", v), vecs[v].spd, vecs[v].data, vecs[v].half,
                  vecs[v].chg_bit, vecs[v].chg_spd, vecs[v].exp_ready);
      end

      // Speed OFF with valid held: nothing may start.
      speed = 2'b00;
      bus.i_snk_tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      bus.i_snk_tx_data  = 32'h1234_5678;
      bus.i_snk_tx_valid = 1'b1;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.o_snk_tx_ready || a || b || busy) seen++;
      end
      check("off_quiet", seen, 0);
      run_word("off_to_50k", 2'b10, 32'h1234_5678, 10, -1, 2'b00, 1'b1);

      // Back-to-back words at 12.5 kbit/s: first edges 36 bit times apart.
      speed = 2'b01;
      bus.i_snk_tx_data  = 32'h0000_0001;
      bus.i_snk_tx_valid = 1'b1;
      to = 0;
      do begin @(negedge clk); to++; end while (!(a | b) && to < 100);
      check("b2b_first_start", longint'(to < 100), 1);
      t1 = cyc;
      bus.i_snk_tx_data = 32'h0000_0002;
      check("b2b_ready_drop", bus.o_snk_tx_ready, 0);
      to = 0;
      while (busy && to < 5000) begin @(negedge clk); to++; end
      while (!(a | b) && to < 5000) begin @(negedge clk); to++; end
      t2 = cyc;
      check("b2b_timeout", longint'(to < 5000), 1);
      check("b2b_period", t2 - t1, 36 * 2 * 40);
      check("b2b_second_bit0", {a, b}, 2'b01);
      bus.i_snk_tx_valid = 1'b0;
      to = 0;
      while (busy && to < 5000) begin @(negedge clk); to++; end
      check("b2b_drain", longint'(to < 5000), 1);

      // Asynchronous reset in the middle of bit 15.
      speed = 2'b11;
      bus.i_snk_tx_data  = 32'hFFFF_FFFF;
      bus.i_snk_tx_valid = 1'b1;
      to = 0;
      do begin @(negedge clk); to++; end while (!(a | b) && to < 100);
      repeat (30 * 5 + 2) @(negedge clk);
      check("rst_mid_pre_line", {a, b}, 2'b10);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_line", {a, b}, 2'b00);
      check("rst_mid_ready", bus.o_snk_tx_ready, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      run_word("after_rst", 2'b11, 32'h0000_0005, 5, -1, 2'b00, 1'b1);

      check("ab_overlap", overlap, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/arinc429_tx.md
Name: arinc429_tx

Overview:
ARINC 429 transmitter: takes 32-bit words from an Avalon-ST sink and serialises them onto the bipolar RZ line pair (A/B) at the configured rate. Counterpart of the ARINC 429 receive channel in the same Qsys subsystem. Enforces the 4-bit-time inter-word NULL gap and exposes a busy status.

Parameters:
IN_AVS_CLK, 32'd50000000, i_avs_clk frequency in Hz
GAP_BITS, 4, inter-word NULL gap length in bit times, must be at least 4

Ports:
i_avs_clk  in  1  system clock, all logic in this single domain
i_avs_rst  in  1  asynchronous, active-high reset
i_snk_tx_valid  in  1  Avalon-ST sink valid
i_snk_tx_data  in  32  word to send; bit 0 is transmitted first
o_snk_tx_ready  out  1  Avalon-ST sink ready
i_arinc429_speed  in  2  00 off, 01 12.5 kbit/s, 10 50 kbit/s, 11 100 kbit/s
o_arinc429_tx_A  out  1  line A driver, high = positive half
o_arinc429_tx_B  out  1  line B driver, high = negative half
o_arinc429_tx_busy  out  1  word or gap in progress
o_arinc429_tx_done  out  1  one-cycle pulse at the end of each word's last bit

Behaviour:
- Reset values: ready 0, A 0, B 0, busy 0, done 0. FSM goes to IDLE. Shift register, bit counter and tick counter are cleared. Reset mid-word aborts the word immediately and leaves the line at NULL.
- Half-bit period HALF = IN_AVS_CLK/(2*rate): 2000, 500 or 250 clocks at 50 MHz. The 16-bit tick counter runs only while busy. It issues a one-cycle tick when it reaches HALF-1, then reloads to 0.
- FSM states:
  - IDLE: ready = (speed != 00). Acceptance happens when valid && ready. On acceptance, latch data and HALF, clear the bit counter, and go to BIT_HI. ready drops in the cycle after acceptance.
  - BIT_HI (first half-bit): A = shreg[0], B = ~shreg[0]. A/B update in the cycle after acceptance, so latency is 1 clock. On tick go to BIT_LO.
  - BIT_LO (second half-bit): A = B = 0. On tick, shift right and increment the bit counter. If 32 bits have been sent, pulse done and go to GAP; otherwise go to BIT_HI.
  - GAP: A = B = 0 for GAP_BITS*2 half-bit ticks, then go to IDLE.
- busy = 1 in BIT_HI, BIT_LO and GAP.
- Speed is sampled only at acceptance. Changing speed mid-word, including to 00, does not alter the current word or gap. A new word is not accepted while speed = 00.
- A and B are never both high. Both outputs are registered and glitch-free.
- Back-to-back valid words: the next word is accepted on the first IDLE cycle after the gap. Minimum word period is 36 bit times when GAP_BITS = 4.
- Data is passed through unmodified unless the optional feature is compiled in.

Optional Feature:
ARINC429_TX_PARITY_GEN_EN
- Defined: bit 31 of the latched word is replaced by odd parity over bits 30:0, so the transmitted 32 bits have an odd number of ones.
- Undefined: bit 31 is transmitted exactly as supplied, and software owns parity.

Decomposition:
- Package arinc429_pkg holds:
  - speed encoding constants SPEED_OFF, SPEED_12K5, SPEED_50K, SPEED_100K;
  - a function returning HALF for a given speed and IN_AVS_CLK;
  - the FSM state typedef;
  - the word width constant 32.
- One sub-module, arinc429_bit_timer: a loadable half-bit tick generator with enable, HALF input and tick output.

Test Plan:
- Speed 11, 50 MHz, send 32'h0000_0001: bit 0 gives A high for 250 clocks then NULL for 250; bits 1..31 give B high 250 / NULL 250 each. done pulses once; busy falls 8×250 clocks after done; ready returns.
- Two words queued back-to-back at speed 01: the second word's first edge comes exactly 36×4000 clocks after the first word's first edge.
- Speed 00 with valid asserted: ready stays 0 and A = B = 0 indefinitely. Switching to 10 causes acceptance and a 500-clock half-bit period.
- Speed changes 11→01 at bit 10: the remaining bits keep 250-clock halves. The next word uses 2000-clock halves.
- i_avs_rst pulsed during bit 15: A = B = 0 and ready = 0 asynchronously. After release with speed set, a new word starts cleanly from bit 0.
- With ARINC429_TX_PARITY_GEN_EN defined, send 32'h0000_0003: transmitted bit 31 = 1. Send 32'h8000_0001: transmitted bit 31 = 0.
